// File: rtl/nibble_deserializer.sv
// Nibble-serial receiver: assembles up to NIBBLES nibbles into a word,
// LS-first or MS-first, with optional sign or zero extension.
module nibble_deserializer #(
   parameter int NIBBLES = 8,
   parameter int IDX_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [IDX_W-1:0]     nibbles_num,
   input  logic                 reverse_direction,
   input  logic                 sign_ext,
   input  logic [3:0]           nib,
   input  logic                 nib_valid,
   output logic                 nib_ready,
   output logic [4*NIBBLES-1:0] word,
   output logic                 word_valid,
   input  logic                 word_ready
);

   localparam int W = 4 * NIBBLES;
   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] len;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] len_in;
   logic             dir;
   logic             ext;
   logic             load;
   logic             last;
   logic             fill;
   logic [W-1:0]     acc;
   logic [W-1:0]     acc_next;
   logic [W-1:0]     word_next;

   assign len_in = (nibbles_num > MAX_IDX) ? MAX_IDX : nibbles_num;
   assign load   = start && (state != HOLD);
   assign last   = dir ? (idx == '0) : (idx == len);

   // The MS nibble is taken after the write so len=0 reverse sees nib.
   always_comb begin
      acc_next  = acc;
      fill      = 1'b0;
      word_next = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) acc_next[4*i +: 4] = nib;
      end
      for (int i = 0; i < NIBBLES; i++) begin
         if (len == IDX_W'(i)) fill = ext & acc_next[4*i+3];
      end
      for (int i = 0; i < NIBBLES; i++) begin
         if (IDX_W'(i) > len) word_next[4*i +: 4] = {4{fill}};
         else                 word_next[4*i +: 4] = acc_next[4*i +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      nib_ready  = 1'b0;
      word_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_next = COLLECT;
         end
         COLLECT: begin
            nib_ready = 1'b1;
            if (start)                  state_next = COLLECT;
            else if (nib_valid && last) state_next = HOLD;
         end
         HOLD: begin
            word_valid = 1'b1;
            if (word_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len  <= '0;
         idx  <= '0;
         dir  <= 1'b0;
         ext  <= 1'b0;
         acc  <= '0;
         word <= '0;
      end else if (load) begin
         len <= len_in;
         dir <= reverse_direction;
         ext <= sign_ext;
         acc <= '0;
         idx <= reverse_direction ? len_in : '0;
      end else if (state == COLLECT && nib_valid) begin
         acc <= acc_next;
         if (last)     word <= word_next;
         else if (dir) idx  <= idx - 1'b1;
         else          idx  <= idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Scoreboard bench for nibble_deserializer: directed transfers on an
// 8-nibble instance and a 4-nibble instance for length saturation.
module tb_nibble_deserializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [2:0]  nibbles_num;
   logic        reverse_direction;
   logic        sign_ext;
   logic [3:0]  nib;
   logic        nib_valid;
   logic        nib_ready;
   logic [31:0] word;
   logic        word_valid;
   logic        word_ready;

   logic        s_start;
   logic [2:0]  s_nibbles_num;
   logic        s_reverse;
   logic        s_sign;
   logic [3:0]  s_nib;
   logic        s_nib_valid;
   logic        s_nib_ready;
   logic [15:0] s_word;
   logic        s_word_valid;
   logic        s_word_ready;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [15:0] s_exp_q[$];

   nibble_deserializer #(.NIBBLES(8), .IDX_W(3)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .nibbles_num(nibbles_num),
      .reverse_direction(reverse_direction),
      .sign_ext(sign_ext), .nib(nib), .nib_valid(nib_valid),
      .nib_ready(nib_ready), .word(word),
      .word_valid(word_valid), .word_ready(word_ready)
   );

   nibble_deserializer #(.NIBBLES(4), .IDX_W(3)) u_sat (
      .clk(clk), .rst(rst), .start(s_start),
      .nibbles_num(s_nibbles_num),
      .reverse_direction(s_reverse),
      .sign_ext(s_sign), .nib(s_nib), .nib_valid(s_nib_valid),
      .nib_ready(s_nib_ready), .word(s_word),
      .word_valid(s_word_valid), .word_ready(s_word_ready)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   logic vprev = 1'b0;
   always @(negedge clk) begin
      if (rst) vprev <= 1'b0;
      else begin
         if (word_valid && !vprev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word got %h", word);
            end else chk("word", word, exp_q.pop_front());
         end
         vprev <= word_valid;
      end
   end

   logic s_vprev = 1'b0;
   always @(negedge clk) begin
      if (rst) s_vprev <= 1'b0;
      else begin
         if (s_word_valid && !s_vprev) begin
            if (s_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_sat_word got %h", s_word);
            end else chk("sat_word", {16'h0, s_word},
                         {16'h0, s_exp_q.pop_front()});
         end
         s_vprev <= s_word_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_xfer(input logic [2:0] n, input logic r,
                             input logic s);
      start = 1'b1;
      nibbles_num = n;
      reverse_direction = r;
      sign_ext = s;
      tick();
      start = 1'b0;
      chk("ready_after_start", {31'h0, nib_ready}, 32'h1);
   endtask

   task automatic feed(input logic [3:0] v);
      nib = v;
      nib_valid = 1'b1;
      tick();
   endtask

   task automatic release_word();
      chk("valid_before_release", {31'h0, word_valid}, 32'h1);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      chk("valid_after_release", {31'h0, word_valid}, 32'h0);
   endtask

   task automatic sat_run(input logic r, input logic s,
                          input logic [15:0] nibs, input logic [15:0] exp);
      s_nibbles_num = 3'd6;
      s_reverse = r;
      s_sign = s;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_exp_q.push_back(exp);
      for (int i = 0; i < 4; i++) begin
         s_nib = nibs[4*i +: 4];
         s_nib_valid = 1'b1;
         tick();
         if (i == 2) chk("sat_not_done", {31'h0, s_word_valid}, 32'h0);
      end
      s_nib_valid = 1'b0;
      chk("sat_done", {31'h0, s_word_valid}, 32'h1);
      s_word_ready = 1'b1;
      tick();
      s_word_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      nibbles_num = '0;
      reverse_direction = 1'b0;
      sign_ext = 1'b0;
      nib = '0;
      nib_valid = 1'b0;
      word_ready = 1'b0;
      s_start = 1'b0;
      s_nibbles_num = '0;
      s_reverse = 1'b0;
      s_sign = 1'b0;
      s_nib = '0;
      s_nib_valid = 1'b0;
      s_word_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", {31'h0, nib_ready}, 32'h0);
      chk("rst_valid", {31'h0, word_valid}, 32'h0);
      chk("rst_word", word, 32'h0);
      chk("rst_sat_word", {16'h0, s_word}, 32'h0);

      begin_xfer(3'd3, 1'b0, 1'b0);
      exp_q.push_back(32'h0000_1234);
      feed(4'h4);
      feed(4'h3);
      feed(4'h2);
      chk("t1_not_done", {31'h0, word_valid}, 32'h0);
      feed(4'h1);
      nib_valid = 1'b0;
      chk("t1_valid", {31'h0, word_valid}, 32'h1);
      chk("t1_ready_low", {31'h0, nib_ready}, 32'h0);
      release_word();

      begin_xfer(3'd1, 1'b1, 1'b1);
      exp_q.push_back(32'hFFFF_FFFE);
      feed(4'hF);
      feed(4'hE);
      nib_valid = 1'b0;
      release_word();

      begin_xfer(3'd1, 1'b1, 1'b1);
      exp_q.push_back(32'h0000_007E);
      feed(4'h7);
      feed(4'hE);
      nib_valid = 1'b0;
      release_word();

      begin_xfer(3'd7, 1'b0, 1'b0);
      exp_q.push_back(32'h8765_4321);
      for (int i = 1; i <= 8; i++) begin
         feed(4'(i));
         nib_valid = 1'b0;
         if (i < 8) begin
            chk("t3_gap_valid", {31'h0, word_valid}, 32'h0);
            tick();
         end
      end
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            start = 1'b1;
            nibbles_num = 3'd0;
         end
         chk("t3_stall_valid", {31'h0, word_valid}, 32'h1);
         chk("t3_stall_word", word, 32'h8765_4321);
         tick();
         start = 1'b0;
      end
      release_word();
      chk("t3_word_kept", word, 32'h8765_4321);
      chk("t3_idle_ready", {31'h0, nib_ready}, 32'h0);

      begin_xfer(3'd3, 1'b0, 1'b0);
      feed(4'hA);
      feed(4'hB);
      start = 1'b1;
      nibbles_num = 3'd7;
      nib = 4'hC;
      tick();
      start = 1'b0;
      exp_q.push_back(32'h89AB_CDEF);
      for (int i = 0; i < 7; i++) feed(4'(15 - i));
      chk("t4_seven_accepts", {31'h0, word_valid}, 32'h0);
      feed(4'h8);
      nib_valid = 1'b0;
      chk("t4_eight_accepts", {31'h0, word_valid}, 32'h1);
      release_word();

      begin_xfer(3'd3, 1'b0, 1'b0);
      feed(4'h1);
      feed(4'h2);
      nib_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_collect_ready", {31'h0, nib_ready}, 32'h0);
      chk("rst_collect_valid", {31'h0, word_valid}, 32'h0);
      chk("rst_collect_word", word, 32'h0);

      begin_xfer(3'd0, 1'b0, 1'b0);
      exp_q.push_back(32'h0000_0005);
      feed(4'h5);
      nib_valid = 1'b0;
      tick();
      chk("t5_hold", {31'h0, word_valid}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_hold_ready", {31'h0, nib_ready}, 32'h0);
      chk("rst_hold_valid", {31'h0, word_valid}, 32'h0);
      chk("rst_hold_word", word, 32'h0);

      begin_xfer(3'd0, 1'b1, 1'b1);
      exp_q.push_back(32'hFFFF_FFF9);
      feed(4'h9);
      nib_valid = 1'b0;
      chk("t5_single_valid", {31'h0, word_valid}, 32'h1);
      release_word();

      sat_run(1'b0, 1'b0, 16'h4321, 16'h4321);
      sat_run(1'b1, 1'b1, 16'h3218, 16'h8123);

      tick();
      tick();
      chk("queue_empty", exp_q.size(), 32'h0);
      chk("sat_queue_empty", s_exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
